// File: rtl/neuron_spike_pkg.sv
// Shared constants and helpers for the neuron-side spike receiver.
package neuron_spike_pkg;

  // Width of the saturating statistics counters.
  localparam int unsigned STATS_W = 16;

  // Number of flits making up one packet.
  function automatic int unsigned flits_per_packet(input int unsigned pkt_w,
                                                   input int unsigned flit_w);
    return pkt_w / flit_w;
  endfunction

  // Bit position of the axon id field: it sits just above the x and y address fields.
  function automatic int unsigned axon_field_lsb(input int unsigned x_w,
                                                 input int unsigned y_w);
    return x_w + y_w;
  endfunction

  // Counter/pointer width able to index n entries (never less than one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_pkt_fifo.sv
// Packet FIFO: count-based full/empty, head word visible combinationally.
module spike_pkt_fifo
  import neuron_spike_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = idx_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  // Occupancy after this cycle; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/neuron_spike_rx.sv
// Neuron-side spike receiver: flit reassembly, packet FIFO, axon decode and
// double-buffered spike vector. Define SPIKE_RX_STATS_EN to implement the
// drop_cnt/pkt_cnt statistics counters; otherwise they read as zero.
module neuron_spike_rx
  import neuron_spike_pkg::*;
#(
  parameter int unsigned PACKET_SIZE        = 32,
  parameter int unsigned FLIT_SIZE          = 4,
  parameter int unsigned X_ADDRESS_LENGTH   = 8,
  parameter int unsigned Y_ADDRESS_LENGTH   = 8,
  parameter int unsigned NUM_AXONS          = 2,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                 neuron_clk,
  input  logic                 rst_n,
  input  logic                 flit_valid,
  input  logic [FLIT_SIZE-1:0] flit_data,
  output logic                 flit_ready,
  input  logic                 start,
  output logic [NUM_AXONS-1:0] spike,
  output logic                 busy,
  output logic [STATS_W-1:0]   drop_cnt,
  output logic [STATS_W-1:0]   pkt_cnt
);

  localparam int unsigned FPP      = flits_per_packet(PACKET_SIZE, FLIT_SIZE);
  localparam int unsigned CNT_W    = idx_width(FPP);
  localparam int unsigned AW       = AXON_CNT_BIT_WIDTH;
  localparam int unsigned AW_EXT   = AW + 1;
  localparam int unsigned AXON_LSB = axon_field_lsb(X_ADDRESS_LENGTH, Y_ADDRESS_LENGTH);
  localparam int unsigned LAST_LSB = (FPP - 1) * FLIT_SIZE;

  logic [CNT_W-1:0]       flit_cnt;
  logic [PACKET_SIZE-1:0] pkt_buf;
  logic [PACKET_SIZE-1:0] push_data;
  logic                   last_flit;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [PACKET_SIZE-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   dec_valid;
  logic [AW-1:0]          dec_axon;
  logic [NUM_AXONS-1:0]   hit;
  logic [NUM_AXONS-1:0]   accum;
  logic                   unused_ok;

  assign last_flit  = (flit_cnt == CNT_W'(FPP - 1));
  // Only the final flit of a packet needs FIFO space, so stall only there.
  assign flit_ready = !(last_flit && fifo_full);
  assign accept     = flit_valid && flit_ready;
  assign push       = accept && last_flit;
  assign pop        = !fifo_empty;

  // Assembled packet: earlier flits from the buffer, final flit straight from the bus.
  always_comb begin
    push_data = pkt_buf;
    push_data[LAST_LSB +: FLIT_SIZE] = flit_data;
  end

  // Flit counter and reassembly buffer; first flit lands in the LSBs.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt <= '0;
      pkt_buf  <= '0;
    end else if (accept) begin
      pkt_buf[32'(flit_cnt) * FLIT_SIZE +: FLIT_SIZE] <= flit_data;
      flit_cnt <= last_flit ? '0 : flit_cnt + CNT_W'(1);
    end
  end

  spike_pkt_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (neuron_clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_c    (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Decode stage: always ready, registers the popped axon id with its valid bit.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_axon  <= '0;
    end else begin
      dec_valid <= pop;
      dec_axon  <= fifo_head[AXON_LSB +: AW];
    end
  end

  // One-hot of the decoded axon; out-of-range ids produce no bit.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_AXONS; i++) begin
      hit[i] = dec_valid && ({1'b0, dec_axon} == AW_EXT'(i));
    end
  end

  // Double buffer: start publishes this timestep's spikes, including a same-cycle hit.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      accum <= '0;
      spike <= '0;
    end else if (start) begin
      spike <= accum | hit;
      accum <= '0;
    end else begin
      accum <= accum | hit;
    end
  end

  // Busy reflects next-cycle FIFO occupancy or decode-stage valid.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= push || !fifo_empty;
    end
  end

`ifdef SPIKE_RX_STATS_EN
  logic in_range;
  assign in_range = ({1'b0, dec_axon} < AW_EXT'(NUM_AXONS));

  // Saturating counts of decoded packets and dropped out-of-range ids.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (dec_valid && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + STATS_W'(1);
      end
      if (dec_valid && !in_range && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + STATS_W'(1);
      end
    end
  end
`else
  assign drop_cnt = '0;
  assign pkt_cnt  = '0;
`endif

  // Header fields and the last buffer slot are carried but not consumed here.
  assign unused_ok = &{1'b0, fifo_head, pkt_buf[LAST_LSB +: FLIT_SIZE]};

endmodule

// File: tb/tb_neuron_spike_rx.sv
// Bench for neuron_spike_rx: packet-level reference model plus directed and random traffic.
module tb_neuron_spike_rx;

  localparam int PS    = 32;
  localparam int FS    = 4;
  localparam int XL    = 8;
  localparam int YL    = 8;
  localparam int NA    = 3;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FPP   = PS / FS;
  localparam int ALSB  = XL + YL;

  logic          neuron_clk = 1'b0;
  logic          rst_n;
  logic          flit_valid;
  logic [FS-1:0] flit_data;
  logic          flit_ready;
  logic          start;
  logic [NA-1:0] spike;
  logic          busy;
  logic [15:0]   drop_cnt;
  logic [15:0]   pkt_cnt;

  neuron_spike_rx #(
    .PACKET_SIZE        (PS),
    .FLIT_SIZE          (FS),
    .X_ADDRESS_LENGTH   (XL),
    .Y_ADDRESS_LENGTH   (YL),
    .NUM_AXONS          (NA),
    .AXON_CNT_BIT_WIDTH (AW),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .neuron_clk (neuron_clk),
    .rst_n      (rst_n),
    .flit_valid (flit_valid),
    .flit_data  (flit_data),
    .flit_ready (flit_ready),
    .start      (start),
    .spike      (spike),
    .busy       (busy),
    .drop_cnt   (drop_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 neuron_clk = ~neuron_clk;

`ifdef SPIKE_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;
  bit rnd_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packets as a queue, spike sets as plain bit masks.
  int            m_cnt;
  logic [31:0]   m_buf;
  logic [31:0]   m_q[$];
  logic [31:0]   m_head;
  bit            m_dv;
  int            m_da;
  logic [NA-1:0] m_accum;
  logic [NA-1:0] m_spike;
  logic [NA-1:0] m_b;
  int            m_drop;
  int            m_pkt;
  bit            m_busy;
  bit            m_acc;

  function automatic logic [NA-1:0] bit_of(input int a);
    return (a < NA) ? NA'(1 << a) : '0;
  endfunction

  function automatic bit m_ready();
    return !((m_cnt == FPP - 1) && (m_q.size() == DEPTH));
  endfunction

  always @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_buf = '0; m_q.delete(); m_dv = 0; m_da = 0;
      m_accum = '0; m_spike = '0; m_drop = 0; m_pkt = 0; m_busy = 0;
    end else begin
      m_acc = flit_valid && m_ready();
      m_b = m_dv ? bit_of(m_da) : '0;
      if (start) begin
        m_spike = m_accum | m_b;
        m_accum = '0;
      end else begin
        m_accum = m_accum | m_b;
      end
      if (m_dv) begin
        if (m_pkt < 65535) m_pkt++;
        if (m_da >= NA && m_drop < 65535) m_drop++;
      end
      m_dv = 0;
      if (m_q.size() > 0) begin
        m_head = m_q.pop_front();
        m_dv = 1;
        m_da = int'(m_head[ALSB +: AW]);
      end
      if (m_acc) begin
        m_buf[m_cnt * FS +: FS] = flit_data;
        if (m_cnt == FPP - 1) begin
          m_q.push_back(m_buf);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      m_busy = (m_q.size() > 0) || m_dv;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge neuron_clk) begin
    if (checking && rst_n) begin
      check("spike", 32'(spike), 32'(m_spike));
      check("busy", 32'(busy), 32'(m_busy));
      check("flit_ready", 32'(flit_ready), 32'(m_ready()));
      check("drop_cnt", 32'(drop_cnt), STATS ? 32'(m_drop) : 32'd0);
      check("pkt_cnt", 32'(pkt_cnt), STATS ? 32'(m_pkt) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge neuron_clk);
    #2;
  endtask

  task automatic idle(input int n);
    flit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int axon);
    logic [31:0] p;
    p = $urandom;
    p[ALSB +: AW] = AW'(axon);
    return p;
  endfunction

  // Sends one packet flit by flit; returns just after the edge accepting the last flit.
  task automatic send_pkt(input logic [31:0] p, input int gap_max);
    for (int k = 0; k < FPP; k++) begin
      int  waited;
      bit  r;
      waited = 0;
      flit_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
        if (rnd_start) start = ($urandom_range(0, 7) == 0);
        tick();
      end
      flit_valid = 1'b1;
      flit_data  = p[k * FS +: FS];
      r = 1'b0;
      while (!r) begin
        if (rnd_start) start = ($urandom_range(0, 7) == 0);
        @(negedge neuron_clk);
        r = flit_ready;
        tick();
        waited++;
        if (!r && waited > 50) begin
          check("flit_accept_timeout", 32'(waited), 32'd0);
          r = 1'b1;
        end
      end
    end
    flit_valid = 1'b0;
    if (rnd_start) start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flit_valid = 1'b0; flit_data = '0; start = 1'b0;
    repeat (2) @(posedge neuron_clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;
    @(negedge neuron_clk);
    check("rst_spike", 32'(spike), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(flit_ready), 32'd1);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    tick();

    // One packet for axon 1, start ten cycles later.
    send_pkt(mk(1), 0);
    idle(10);
    pulse_start();
    check("single_spike", 32'(spike), 32'b010);
    check("single_busy", 32'(busy), 32'd0);
    check("single_pkt_cnt", 32'(pkt_cnt), STATS ? 32'd1 : 32'd0);

    // Axons 0 and 1, then an empty timestep.
    send_pkt(mk(0), 0);
    send_pkt(mk(1), 0);
    send_pkt(mk(1), 0);
    idle(4);
    pulse_start();
    check("pair_spike", 32'(spike), 32'b011);
    idle(2);
    pulse_start();
    check("empty_spike", 32'(spike), 32'b000);

    // Out-of-range axon id is dropped.
    send_pkt(mk(3), 0);
    idle(4);
    pulse_start();
    check("drop_spike", 32'(spike), 32'b000);
    check("drop_cnt_lit", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);
    check("drop_pkt_cnt", 32'(pkt_cnt), STATS ? 32'd5 : 32'd0);

    // Start at T+2 captures the packet whose last flit was accepted at T.
    send_pkt(mk(2), 0);
    tick();
    pulse_start();
    check("edge_t2_spike", 32'(spike), 32'b100);

    // Start at T+1 is too early; the bit lands in the next timestep.
    send_pkt(mk(2), 0);
    pulse_start();
    check("edge_t1_spike", 32'(spike), 32'b000);
    idle(3);
    pulse_start();
    check("edge_t1_next", 32'(spike), 32'b100);

    // Reset in the middle of a packet discards the partial flits.
    flit_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flit_data = 4'hF;
      tick();
    end
    flit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(mk(0), 0);
    idle(4);
    pulse_start();
    check("midrst_spike", 32'(spike), 32'b001);
    check("midrst_pkt_cnt", 32'(pkt_cnt), STATS ? 32'd1 : 32'd0);

    // Random traffic with random gaps and random timestep boundaries.
    rnd_start = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send_pkt(mk($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 0 : 2);
    end
    rnd_start = 1'b0;
    start = 1'b0;
    idle(5);
    pulse_start();
    idle(3);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
